// File: rtl/axis_merge_pkg.sv
// Shared widths, beat payload and merge FSM encoding for the 2:1 AXI4-Stream packet merger.
package axis_merge_pkg;

    localparam int unsigned DATA_WIDTH = 512;
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ID_WIDTH   = 6;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KEEP_WIDTH-1:0] tkeep;
        logic [ID_WIDTH-1:0]   tid;
        logic                  tlast;
    } axis_beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } merge_state_t;

endpackage

// File: rtl/axis_packet_merge_2to1_if.sv
// AXI4-Stream bundle shared by the merger's two inputs and its output.
interface axis_packet_merge_2to1_if;
    import axis_merge_pkg::*;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tid, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tid, tlast, output tready);

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry FIFO-ordered register buffer; s_ready is registered so no ready path crosses it.
module axis_skid_buffer
    import axis_merge_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  axis_beat_t s_beat_i,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output axis_beat_t m_beat_o
);

    logic [1:0] count_q, count_d;
    axis_beat_t head_q, head_d;
    axis_beat_t tail_q, tail_d;
    logic       s_ready_q, s_ready_d;
    logic       m_valid_q, m_valid_d;
    logic       push, pop;

    assign push = s_valid_i && s_ready_q;
    assign pop  = m_valid_q && m_ready_i;

    // Head always holds the oldest beat; tail is only used when both entries are live.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (pop && (count_q == 2'd2)) begin
            head_d = tail_q;
        end
        if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
            head_d = s_beat_i;
        end
        if (push && (count_q == 2'd1) && !pop) begin
            tail_d = s_beat_i;
        end
        s_ready_d = (count_d != 2'd2);
        m_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q   <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_beat_o  = head_q;

endmodule

// File: rtl/axis_packet_merge_2to1.sv
// Round-robin, packet-granular 2:1 AXI4-Stream merger with registered skid output and packet counters.
module axis_packet_merge_2to1
    import axis_merge_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    axis_packet_merge_2to1_if.slave     input0_axis,
    axis_packet_merge_2to1_if.slave     input1_axis,
    axis_packet_merge_2to1_if.master    output_axis,
    output logic [CNT_WIDTH-1:0]        pkt_count0,
    output logic [CNT_WIDTH-1:0]        pkt_count1
);

    merge_state_t         state_q;
    logic                 prio_q;
    logic [CNT_WIDTH-1:0] cnt0_q;
    logic [CNT_WIDTH-1:0] cnt1_q;

    logic       grant_vld_c;
    logic       grant_sel_c;
    logic       sel_valid;
    logic       skid_s_valid;
    logic       skid_s_ready;
    logic       skid_m_valid;
    logic       accept;
    axis_beat_t in0_beat;
    axis_beat_t in1_beat;
    axis_beat_t sel_beat;
    axis_beat_t out_beat;

    assign in0_beat = {input0_axis.tdata, input0_axis.tkeep, input0_axis.tid, input0_axis.tlast};
    assign in1_beat = {input1_axis.tdata, input1_axis.tkeep, input1_axis.tid, input1_axis.tlast};

    // Grant is free only between packets; mid-packet it is pinned to the owning input.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_sel_c = 1'b0;
        case (state_q)
            IDLE: begin
                grant_vld_c = input0_axis.tvalid || input1_axis.tvalid;
                grant_sel_c = input1_axis.tvalid && (!input0_axis.tvalid || prio_q);
            end
            PASS0: begin
                grant_vld_c = 1'b1;
                grant_sel_c = 1'b0;
            end
            PASS1: begin
                grant_vld_c = 1'b1;
                grant_sel_c = 1'b1;
            end
            default: begin
                grant_vld_c = 1'b0;
                grant_sel_c = 1'b0;
            end
        endcase
    end

    assign sel_valid    = grant_sel_c ? input1_axis.tvalid : input0_axis.tvalid;
    assign sel_beat     = grant_sel_c ? in1_beat : in0_beat;
    assign skid_s_valid = grant_vld_c && sel_valid;
    assign accept       = skid_s_valid && skid_s_ready;

    assign input0_axis.tready = grant_vld_c && !grant_sel_c && skid_s_ready;
    assign input1_axis.tready = grant_vld_c &&  grant_sel_c && skid_s_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else if (accept) begin
            if (sel_beat.tlast) begin
                state_q <= IDLE;
                prio_q  <= !grant_sel_c;
                if (grant_sel_c) begin
                    cnt1_q <= cnt1_q + CNT_WIDTH'(1);
                end else begin
                    cnt0_q <= cnt0_q + CNT_WIDTH'(1);
                end
            end else begin
                state_q <= grant_sel_c ? PASS1 : PASS0;
            end
        end
    end

    axis_skid_buffer u_skid (
        .clock     (clock),
        .reset     (reset),
        .s_valid_i (skid_s_valid),
        .s_ready_o (skid_s_ready),
        .s_beat_i  (sel_beat),
        .m_valid_o (skid_m_valid),
        .m_ready_i (output_axis.tready),
        .m_beat_o  (out_beat)
    );

    assign output_axis.tvalid = skid_m_valid;
    assign output_axis.tdata  = out_beat.tdata;
    assign output_axis.tkeep  = out_beat.tkeep;
    assign output_axis.tid    = out_beat.tid;
    assign output_axis.tlast  = out_beat.tlast;

    assign pkt_count0 = cnt0_q;
    assign pkt_count1 = cnt1_q;

endmodule

// File: tb/tb_axis_packet_merge_2to1.sv
// Directed bench for the 2:1 packet merger: arbitration order, stalls, backpressure, reset and counter wrap.
module tb_axis_packet_merge_2to1;
    import axis_merge_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axis_packet_merge_2to1_if in0_if ();
    axis_packet_merge_2to1_if in1_if ();
    axis_packet_merge_2to1_if out_if ();

    logic [CNT_W-1:0] pkt_count0;
    logic [CNT_W-1:0] pkt_count1;

    axis_packet_merge_2to1 #(.CNT_WIDTH(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .input0_axis (in0_if),
        .input1_axis (in1_if),
        .output_axis (out_if),
        .pkt_count0  (pkt_count0),
        .pkt_count1  (pkt_count1)
    );

    int checks = 0;
    int errors = 0;

    axis_beat_t src0_q[$];
    axis_beat_t src1_q[$];
    axis_beat_t exp_q[$];

    logic en0 = 1'b1;
    logic en1 = 1'b1;
    logic out_rdy = 1'b1;
    logic rdy0_s, rdy1_s;
    logic held_vld = 1'b0;
    axis_beat_t held_beat;
    int cyc = 0;
    int first_in_cyc, first_out_cyc, last_out_cyc, out_beats;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic axis_beat_t mk(input int s, input int p, input int b, input logic last);
        axis_beat_t r;
        r.tdata = {16{{8'(s), 8'(p), 8'(b), 8'hA5}}};
        r.tkeep = '1;
        r.tid   = 6'(s * 16 + p);
        r.tlast = last;
        return r;
    endfunction

    task automatic drive();
        axis_beat_t z;
        z = '0;
        in0_if.tvalid = en0 && (src0_q.size() > 0);
        in1_if.tvalid = en1 && (src1_q.size() > 0);
        if (src0_q.size() > 0) {in0_if.tdata, in0_if.tkeep, in0_if.tid, in0_if.tlast} = src0_q[0];
        else                   {in0_if.tdata, in0_if.tkeep, in0_if.tid, in0_if.tlast} = z;
        if (src1_q.size() > 0) {in1_if.tdata, in1_if.tkeep, in1_if.tid, in1_if.tlast} = src1_q[0];
        else                   {in1_if.tdata, in1_if.tkeep, in1_if.tid, in1_if.tlast} = z;
        out_if.tready = out_rdy;
    endtask

    // One clock: drive sources, sample handshakes at negedge, retire accepted source beats.
    task automatic step();
        axis_beat_t ob;
        logic fire0, fire1;
        drive();
        @(negedge clock);
        rdy0_s = in0_if.tready;
        rdy1_s = in1_if.tready;
        ob = {out_if.tdata, out_if.tkeep, out_if.tid, out_if.tlast};
        if (held_vld) begin
            chk("hold_valid", 640'(out_if.tvalid), 640'(1));
            chk("hold_payload", 640'(ob), 640'(held_beat));
        end
        if (out_if.tvalid && out_if.tready) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 640'(exp_q.size()), 640'(1));
            else                   chk("out_beat", 640'(ob), 640'(exp_q.pop_front()));
            out_beats++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
        end
        held_vld  = out_if.tvalid && !out_if.tready;
        held_beat = ob;
        fire0 = in0_if.tvalid && in0_if.tready;
        fire1 = in1_if.tvalid && in1_if.tready;
        if ((fire0 || fire1) && first_in_cyc < 0) first_in_cyc = cyc;
        @(posedge clock);
        #1;
        cyc++;
        if (fire0) void'(src0_q.pop_front());
        if (fire1) void'(src1_q.pop_front());
    endtask

    task automatic run_until_done(input int budget, input string tag);
        int i;
        i = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || exp_q.size() > 0) && i < budget) begin
            step();
            i++;
        end
        chk({tag, "_drained"}, 640'(exp_q.size() + src0_q.size() + src1_q.size()), 640'(0));
    endtask

    task automatic clear_trace();
        first_in_cyc  = -1;
        first_out_cyc = -1;
        last_out_cyc  = -1;
        out_beats     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axis_beat_t b;

        // Reset with both inputs requesting: nothing may be accepted or presented.
        reset = 1'b0;
        drive();
        in0_if.tvalid = 1'b1;
        in1_if.tvalid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_tvalid", 640'(out_if.tvalid), 640'(0));
        chk("rst_in0_tready", 640'(in0_if.tready), 640'(0));
        chk("rst_in1_tready", 640'(in1_if.tready), 640'(0));
        chk("rst_out_tdata", 640'(out_if.tdata), 640'(0));
        chk("rst_cnt0", 640'(pkt_count0), 640'(0));
        chk("rst_cnt1", 640'(pkt_count1), 640'(0));
        reset = 1'b1;
        step();

        // Both inputs continuously offer 2-beat packets: strict 0,1,0,1 alternation at full rate.
        clear_trace();
        for (int p = 0; p < 4; p++) begin
            src0_q.push_back(mk(0, p, 0, 1'b0));
            src0_q.push_back(mk(0, p, 1, 1'b1));
            src1_q.push_back(mk(1, p, 0, 1'b0));
            src1_q.push_back(mk(1, p, 1, 1'b1));
        end
        for (int p = 0; p < 4; p++) begin
            exp_q.push_back(mk(0, p, 0, 1'b0));
            exp_q.push_back(mk(0, p, 1, 1'b1));
            exp_q.push_back(mk(1, p, 0, 1'b0));
            exp_q.push_back(mk(1, p, 1, 1'b1));
        end
        run_until_done(60, "t2");
        chk("t2_beats", 640'(out_beats), 640'(16));
        chk("t2_span", 640'(last_out_cyc - first_out_cyc), 640'(15));
        chk("t2_latency", 640'(first_out_cyc - first_in_cyc), 640'(1));
        chk("t2_cnt0", 640'(pkt_count0), 640'(4));
        chk("t2_cnt1", 640'(pkt_count1), 640'(4));

        // Single 3-beat packet on input 0, tid 5, short last beat.
        clear_trace();
        for (int k = 0; k < 3; k++) begin
            b = mk(0, 8, k, k == 2);
            b.tid = 6'd5;
            if (k == 2) b.tkeep = 64'h0000_0000_0000_00FF;
            src0_q.push_back(b);
            exp_q.push_back(b);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_in1_tready", 640'(rdy1_s), 640'(0));
        end
        chk("t1_drained", 640'(exp_q.size()), 640'(0));
        chk("t1_latency", 640'(first_out_cyc - first_in_cyc), 640'(1));
        chk("t1_idle_out", 640'(out_if.tvalid), 640'(0));
        chk("t1_cnt0", 640'(pkt_count0), 640'(5));
        chk("t1_cnt1", 640'(pkt_count1), 640'(4));

        // Input 0 stalls mid-packet for 5 cycles; input 1 must wait for its tlast.
        for (int k = 0; k < 3; k++) begin
            src0_q.push_back(mk(0, 9, k, k == 2));
            exp_q.push_back(mk(0, 9, k, k == 2));
        end
        src1_q.push_back(mk(1, 9, 0, 1'b0));
        src1_q.push_back(mk(1, 9, 1, 1'b1));
        exp_q.push_back(mk(1, 9, 0, 1'b0));
        exp_q.push_back(mk(1, 9, 1, 1'b1));
        en0 = 1'b1;
        en1 = 1'b0;
        step();
        en0 = 1'b0;
        en1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_in1_blocked", 640'(rdy1_s), 640'(0));
        end
        en0 = 1'b1;
        run_until_done(40, "t3");
        chk("t3_cnt0", 640'(pkt_count0), 640'(6));
        chk("t3_cnt1", 640'(pkt_count1), 640'(5));

        // Output ready 1,0,0,1 under a 4-beat packet: two beats absorbed, then input stalls.
        for (int k = 0; k < 4; k++) begin
            src0_q.push_back(mk(0, 10, k, k == 3));
            exp_q.push_back(mk(0, 10, k, k == 3));
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        step();
        chk("t4_second_absorbed", 640'(rdy0_s), 640'(1));
        step();
        chk("t4_stall_full", 640'(rdy0_s), 640'(0));
        out_rdy = 1'b1;
        step();
        chk("t4_stall_pop", 640'(rdy0_s), 640'(0));
        run_until_done(40, "t4");
        chk("t4_cnt0", 640'(pkt_count0), 640'(7));

        // Reset mid-packet in PASS1 with 2 beats buffered.
        out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) src1_q.push_back(mk(1, 11, k, k == 3));
        step();
        step();
        step();
        chk("t5_full_stall", 640'(rdy1_s), 640'(0));
        chk("t5_pre_valid", 640'(out_if.tvalid), 640'(1));
        reset = 1'b0;
        in0_if.tvalid = 1'b1;
        @(posedge clock);
        #1;
        chk("t5_rst_out_tvalid", 640'(out_if.tvalid), 640'(0));
        chk("t5_rst_cnt0", 640'(pkt_count0), 640'(0));
        chk("t5_rst_cnt1", 640'(pkt_count1), 640'(0));
        chk("t5_rst_in0_tready", 640'(in0_if.tready), 640'(0));
        chk("t5_rst_in1_tready", 640'(in1_if.tready), 640'(0));
        reset = 1'b1;
        held_vld = 1'b0;
        src1_q.delete();
        out_rdy = 1'b1;
        src0_q.push_back(mk(0, 12, 0, 1'b1));
        src1_q.push_back(mk(1, 12, 0, 1'b1));
        exp_q.push_back(mk(0, 12, 0, 1'b1));
        exp_q.push_back(mk(1, 12, 0, 1'b1));
        run_until_done(20, "t5");
        chk("t5_cnt0", 640'(pkt_count0), 640'(1));
        chk("t5_cnt1", 640'(pkt_count1), 640'(1));

        // 17 single-beat packets on input 1 wrap a 4-bit counter to 1.
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        held_vld = 1'b0;
        for (int k = 0; k < 17; k++) begin
            src1_q.push_back(mk(1, k, 0, 1'b1));
            exp_q.push_back(mk(1, k, 0, 1'b1));
        end
        run_until_done(60, "t6");
        chk("t6_cnt1_wrap", 640'(pkt_count1), 640'(1));
        chk("t6_cnt0", 640'(pkt_count0), 640'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_packet_merge_2to1.md
Name: axis_packet_merge_2to1

Overview:
- Two-input, one-output AXI4-Stream packet merger: the fan-in counterpart of the stream duplicator.
- Recombines two independently buffered 512-bit streams, for example the two branches after duplication and per-branch processing, into one stream.
- Arbitrates round-robin at packet granularity; a granted input keeps the output until its tlast beat.
- Output is registered through a 2-entry skid buffer, giving full throughput and no combinational ready path from output to inputs.

Parameters:
- DATA_WIDTH, 512, tdata width in bits.
- KEEP_WIDTH, 64, tkeep width; must equal DATA_WIDTH/8.
- ID_WIDTH, 6, tid width.
- CNT_WIDTH, 32, width of the per-input packet counters.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-low reset.
- input0_axis_tvalid/tready/tdata/tkeep/tid/tlast  in/out/in/in/in/in  1/1/DATA_WIDTH/KEEP_WIDTH/ID_WIDTH/1  slave stream 0.
- input1_axis_tvalid/tready/tdata/tkeep/tid/tlast  in/out/in/in/in/in  1/1/DATA_WIDTH/KEEP_WIDTH/ID_WIDTH/1  slave stream 1.
- output_axis_tvalid/tready/tdata/tkeep/tid/tlast  out/in/out/out/out/out  1/1/DATA_WIDTH/KEEP_WIDTH/ID_WIDTH/1  merged master stream.
- pkt_count0  out  CNT_WIDTH  number of input-0 tlast beats accepted.
- pkt_count1  out  CNT_WIDTH  number of input-1 tlast beats accepted.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE; priority pointer is set to input 0; skid buffer is emptied; both counters are cleared.
  - output_axis_tvalid=0, both inputN_axis_tready=0, data outputs=0.
  - Reset applied mid-packet discards buffered beats. The downstream sees a truncated packet; this is accepted behaviour.
- FSM states:
  - IDLE: no packet in progress. Grant is computed combinationally in this cycle:
    - only input k valid -> grant k;
    - both valid -> grant the priority input;
    - neither valid -> no grant.
  - PASS0 / PASS1: packet from input 0 / input 1 in progress. Grant is fixed to that input.
- Ready rules:
  - inputN_axis_tready = (grant==N) && skid_s_ready. The non-granted input's ready is 0.
  - skid_s_ready is a registered signal (buffer not full).
- Transfer: a beat transfers on an input when tvalid && tready. tdata, tkeep, tid and tlast are passed unmodified.
- State transitions:
  - IDLE, accepted beat with tlast=0 -> PASSk.
  - IDLE, accepted beat with tlast=1 -> stay IDLE (single-beat packet).
  - PASSk, accepted beat with tlast=1 -> IDLE.
  - No accepted beat -> state held. An input stalling mid-packet keeps the grant indefinitely; there is no timeout.
- Priority pointer: on each accepted tlast beat from input k, priority becomes 1-k. Back-to-back packets therefore alternate when both inputs are valid.
- Latency and throughput:
  - Latency from input handshake to output_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 beat/cycle, including packet boundaries: the first beat of the next packet is accepted in the cycle after the previous tlast.
- Skid buffer:
  - 2 entries, FIFO order.
  - s_ready deasserts only when both entries are occupied.
  - With output_axis_tready low, at most 2 beats are absorbed after which inputs stall.
  - Simultaneous push and pop when full is not possible, because s_ready=0.
- Output stability: output payload is stable while output_axis_tvalid=1 and output_axis_tready=0. tvalid never drops without a handshake.
- Counters:
  - pkt_countN increments by 1 on each accepted input-N beat with tlast=1.
  - Counters wrap modulo 2^CNT_WIDTH.
  - Counts are updated at input acceptance, not at output.
- Packet integrity: beats of different packets never interleave on the output.

Decomposition:
- Shared package axis_merge_pkg:
  - width localparams: DATA_WIDTH, KEEP_WIDTH, ID_WIDTH;
  - packed struct axis_beat_t {tdata, tkeep, tid, tlast};
  - FSM enum merge_state_t {IDLE, PASS0, PASS1}.
- Sub-module axis_skid_buffer: 2-entry registered buffer on axis_beat_t with s_valid/s_ready/m_valid/m_ready, same clock and reset.
- Top level holds the FSM, grant mux, priority pointer and counters.

Test Plan:
- Only input0 sends a 3-beat packet (tid=5, tkeep=all ones, last beat tkeep=0x0000_0000_0000_00FF), output_axis_tready=1 -> output shows the 3 beats with identical fields one cycle later; pkt_count0=1; input1_axis_tready stays 0.
- Both inputs hold 2-beat packets continuously, output_axis_tready=1, 8 packets total -> output order is 0,1,0,1,...; no interleaving; 16 beats in 16 consecutive cycles; pkt_count0=pkt_count1=4.
- Input0 packet in progress, input0 tvalid drops for 5 cycles mid-packet while input1 is valid -> input1 stays ungranted; the packet resumes and completes before input1's packet starts.
- output_axis_tready toggles 1,0,0,1 while a 4-beat packet streams in -> no beat is lost or duplicated; inputs stall after 2 absorbed beats; output payload is stable during stalls.
- Reset asserted low for 1 cycle with 2 beats buffered and the FSM in PASS1 -> next cycle output_axis_tvalid=0, counters=0, state IDLE; first post-reset contention is granted to input 0.
- CNT_WIDTH=4, 17 single-beat packets on input1 -> pkt_count1=1 (wrap verified).
